// File: rtl/snare_env_ctrl.sv
//==============================================================================
// Module      : snare_env_ctrl
// Description : Snare voice envelope sequencer. A trigger pulses the oscillator
//               phase-sync, then runs a shared attack/hold phase followed by
//               independent decays for the sine, triangle and noise gains.
//               Optional build macro SNARE_ENV_EXP_DECAY_EN selects an
//               exponential decay law instead of the default linear one.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module snare_env_ctrl #(
    parameter int WIDTH       = 12,
    parameter int ATTACK_STEP = 512,
    parameter int HOLD_TICKS  = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             smpl_tick,
    input  logic             trigger,
    input  logic [WIDTH-1:0] decay_sine,
    input  logic [WIDTH-1:0] decay_tri,
    input  logic [WIDTH-1:0] decay_noise,
    output logic [WIDTH-1:0] env_sine,
    output logic [WIDTH-1:0] env_tri,
    output logic [WIDTH-1:0] env_noise,
    output logic             osc_sync,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_attack = 2'd1;
    localparam logic [1:0] c_hold   = 2'd2;
    localparam logic [1:0] c_decay  = 2'd3;

    localparam int               CNT_W      = $clog2(HOLD_TICKS + 2);
    localparam logic [WIDTH-1:0] c_full     = '1;
    localparam logic [WIDTH:0]   c_atk_inc  = (WIDTH+1)'(ATTACK_STEP);
    localparam logic [CNT_W-1:0] c_hold_ini = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hold_cnt;

    logic [WIDTH-1:0] w_atk_sine, w_atk_tri, w_atk_noise;
    logic [WIDTH-1:0] w_dec_sine, w_dec_tri, w_dec_noise;
    logic             w_atk_full;
    logic             w_dec_zero;

    // Attack: widen by one bit so the sum cannot wrap, then clamp to full scale
    function automatic logic [WIDTH-1:0] attack_one(input logic [WIDTH-1:0] lvl);
        logic [WIDTH:0] sum;
        sum = {1'b0, lvl} + c_atk_inc;
        return (sum > {1'b0, c_full}) ? c_full : sum[WIDTH-1:0];
    endfunction

    // Decay one channel; floors at zero so a channel that finished stays silent
    function automatic logic [WIDTH-1:0] decay_one(input logic [WIDTH-1:0] lvl,
                                                   input logic [WIDTH-1:0] step);
`ifdef SNARE_ENV_EXP_DECAY_EN
        logic [WIDTH:0] dec;
        dec = {1'b0, (lvl >> step[3:0])} + (WIDTH+1)'(1);
        return ({1'b0, lvl} > dec) ? (lvl - dec[WIDTH-1:0]) : '0;
`else
        // A zero step would stall the note forever, so it is promoted to one
        logic [WIDTH-1:0] s;
        s = (step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;
        return (lvl > s) ? (lvl - s) : '0;
`endif
    endfunction

    // Candidate next levels for the attack and decay phases
    always_comb begin
        w_atk_sine  = attack_one(env_sine);
        w_atk_tri   = attack_one(env_tri);
        w_atk_noise = attack_one(env_noise);
        w_dec_sine  = decay_one(env_sine,  decay_sine);
        w_dec_tri   = decay_one(env_tri,   decay_tri);
        w_dec_noise = decay_one(env_noise, decay_noise);
        w_atk_full  = (w_atk_sine == c_full) && (w_atk_tri == c_full) &&
                      (w_atk_noise == c_full);
        w_dec_zero  = (w_dec_sine == '0) && (w_dec_tri == '0) &&
                      (w_dec_noise == '0);
    end

    // Sequencer: trigger overrides everything, levels move only on sample ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_hold_cnt <= '0;
            env_sine   <= '0;
            env_tri    <= '0;
            env_noise  <= '0;
            osc_sync   <= 1'b0;
            done       <= 1'b0;
        end else begin
            osc_sync <= 1'b0;
            done     <= 1'b0;
            if (trigger) begin
                // Levels are kept so a retrigger ramps up from where it is
                r_state  <= c_attack;
                osc_sync <= 1'b1;
            end else if (smpl_tick) begin
                case (r_state)
                    c_attack: begin
                        env_sine  <= w_atk_sine;
                        env_tri   <= w_atk_tri;
                        env_noise <= w_atk_noise;
                        if (w_atk_full) begin
                            if (HOLD_TICKS == 0) begin
                                r_state <= c_decay;
                            end else begin
                                r_state    <= c_hold;
                                r_hold_cnt <= c_hold_ini;
                            end
                        end
                    end
                    c_hold: begin
                        if (r_hold_cnt != '0) begin
                            r_hold_cnt <= r_hold_cnt - c_cnt_one;
                        end
                        if (r_hold_cnt <= c_cnt_one) begin
                            r_state <= c_decay;
                        end
                    end
                    c_decay: begin
                        env_sine  <= w_dec_sine;
                        env_tri   <= w_dec_tri;
                        env_noise <= w_dec_noise;
                        if (w_dec_zero) begin
                            r_state <= c_idle;
                            done    <= 1'b1;
                        end
                    end
                    default: begin
                        env_sine  <= '0;
                        env_tri   <= '0;
                        env_noise <= '0;
                    end
                endcase
            end
        end
    end

    // Busy whenever a note is in progress
    always_comb begin
        busy = (r_state != c_idle);
    end

endmodule

`default_nettype wire

// File: tb/tb_snare_env_ctrl.sv
//==============================================================================
// Module      : tb_snare_env_ctrl
// Description : Self-checking bench for snare_env_ctrl with a behavioural
//               envelope model feeding a scoreboard queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_snare_env_ctrl;

    localparam int W = 12;

    localparam int M_IDLE = 0;
    localparam int M_ATK  = 1;
    localparam int M_HLD  = 2;
    localparam int M_DEC  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         smpl_tick;
    logic         trigger;
    logic [W-1:0] decay_sine, decay_tri, decay_noise;
    logic [W-1:0] env_sine, env_tri, env_noise;
    logic         osc_sync, busy, done;

    always #5 clk = ~clk;

    snare_env_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .smpl_tick   (smpl_tick),
        .trigger     (trigger),
        .decay_sine  (decay_sine),
        .decay_tri   (decay_tri),
        .decay_noise (decay_noise),
        .env_sine    (env_sine),
        .env_tri     (env_tri),
        .env_noise   (env_noise),
        .osc_sync    (osc_sync),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        string       tag;
        logic [38:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_state, m_s, m_t, m_n, m_cnt;
    bit m_osc, m_done;

    function automatic logic [38:0] observed();
        return {env_sine, env_tri, env_noise, osc_sync, busy, done};
    endfunction

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int dstep(input int lvl, input int st);
`ifdef SNARE_ENV_EXP_DECAY_EN
        int d = (lvl >> (st % 16)) + 1;
`else
        int d = (st == 0) ? 1 : st;
`endif
        return (lvl > d) ? lvl - d : 0;
    endfunction

    function automatic int atk(input int lvl);
        return (lvl + 512 > 4095) ? 4095 : lvl + 512;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_s = 0; m_t = 0; m_n = 0; m_cnt = 0;
        m_osc = 0; m_done = 0;
    endtask

    task automatic model_step(input bit trig, input bit tk);
        m_osc  = 0;
        m_done = 0;
        if (trig) begin
            m_state = M_ATK;
            m_osc   = 1;
        end else if (tk) begin
            if (m_state == M_ATK) begin
                m_s = atk(m_s); m_t = atk(m_t); m_n = atk(m_n);
                if (m_s == 4095 && m_t == 4095 && m_n == 4095) begin
                    m_state = M_HLD;
                    m_cnt   = 48;
                end
            end else if (m_state == M_HLD) begin
                m_cnt--;
                if (m_cnt == 0) m_state = M_DEC;
            end else if (m_state == M_DEC) begin
                m_s = dstep(m_s, int'(decay_sine));
                m_t = dstep(m_t, int'(decay_tri));
                m_n = dstep(m_n, int'(decay_noise));
                if (m_s == 0 && m_t == 0 && m_n == 0) begin
                    m_state = M_IDLE;
                    m_done  = 1;
                end
            end
        end
    endtask

    // One clock of stimulus: expected result queued at drive time, checked after the edge
    task automatic step(input string tag, input bit trig, input bit tk);
        exp_t e;
        exp_t got;
        @(negedge clk);
        trigger   = trig;
        smpl_tick = tk;
        model_step(trig, tk);
        e.tag = tag;
        e.v   = {12'(m_s), 12'(m_t), 12'(m_n), m_osc, (m_state != M_IDLE), m_done};
        sb.push_back(e);
        @(posedge clk);
        #1;
        trigger   = 1'b0;
        smpl_tick = 1'b0;
        got = sb.pop_front();
        check(got.tag, observed(), got.v);
    endtask

    initial begin
        reset       = 1'b1;
        trigger     = 1'b0;
        smpl_tick   = 1'b0;
        decay_sine  = '0;
        decay_tri   = '0;
        decay_noise = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observed(), 39'd0);
        @(negedge clk);
        reset = 1'b0;

        // IDLE ignores sample ticks
        step("idle_tick", 0, 1);
        step("idle_tick", 0, 1);

        // First note: trigger, attack ramp with one tick-less cycle in between
        step("trig_idle", 1, 0);
        for (int i = 0; i < 8; i++) begin
            step("attack", 0, 1);
            if (i == 2) step("attack_no_tick", 0, 0);
        end
        check("attack_full", {27'd0, env_sine}, 39'd4095);
        for (int i = 0; i < 48; i++) step("hold", 0, 1);

        // Linear decay with a zero step on the triangle channel
        decay_sine  = 12'd16;
        decay_tri   = 12'd0;
        decay_noise = 12'd64;
        for (int i = 0; i < 5000 && m_state == M_DEC; i++) begin
            step("decay_lin", 0, 1);
            if (i == 62) check("noise_63", {27'd0, env_noise}, 39'd63);
            if (i == 63) check("noise_zero", {27'd0, env_noise}, 39'd0);
        end
        if (m_state != M_IDLE) check("decay_budget", 39'd0, 39'd1);
        step("idle_after_done", 0, 1);

        // Second note, decayed partway, then retriggered
        step("trig2", 1, 0);
        for (int i = 0; i < 200 && m_state != M_DEC; i++) step("atk_hold2", 0, 1);
        decay_sine  = 12'd419;
        decay_tri   = 12'd1;
        decay_noise = 12'd619;
        for (int i = 0; i < 5; i++) step("decay2", 0, 1);
        check("sine_2000", {27'd0, env_sine}, 39'd2000);
        step("retrig_with_tick", 1, 1);
        step("retrig_attack", 0, 1);
        check("sine_2512", {27'd0, env_sine}, 39'd2512);
        for (int i = 0; i < 3; i++) step("trig_held", 1, 1);
        for (int i = 0; i < 200 && m_state != M_DEC; i++) step("atk_hold3", 0, 1);
        for (int i = 0; i < 5; i++) step("decay3", 0, 1);
        check("noise_1000", {27'd0, env_noise}, 39'd1000);

        // Asynchronous reset mid-decay: outputs clear before any clock edge
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset", observed(), 39'd0);
        @(posedge clk);
        #1;
        check("reset_no_done", observed(), 39'd0);
        @(negedge clk);
        reset = 1'b0;
        step("post_reset_idle", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
